// File: rtl/hue_seq_pkg.sv
// Shared types and helpers for the hue sequencer and its downstream PWM stage.
// Sector encoding and duty-width rule live here so both sides agree on them.
package hue_seq_pkg;

    typedef enum logic [2:0] {
        S_G_UP = 3'd0,
        S_R_DN = 3'd1,
        S_B_UP = 3'd2,
        S_G_DN = 3'd3,
        S_R_UP = 3'd4,
        S_B_DN = 3'd5
    } sector_t;

    localparam int NUM_SECTORS = 6;

    // Bits needed to represent a duty of 0..interval inclusive.
    function automatic int duty_width(input int interval);
        return $clog2(interval + 1);
    endfunction

    function automatic sector_t next_sector(input sector_t s);
        case (s)
            S_G_UP:  return S_R_DN;
            S_R_DN:  return S_B_UP;
            S_B_UP:  return S_G_DN;
            S_G_DN:  return S_R_UP;
            S_R_UP:  return S_B_DN;
            S_B_DN:  return S_G_UP;
            default: return S_G_UP;
        endcase
    endfunction

endpackage

// File: rtl/hue_step_timer.sv
// Counts enabled period_end pulses and emits a step pulse on the one that
// completes PERIODS_PER_STEP pulses; the counter then restarts from zero.
module hue_step_timer #(
    parameter int PERIODS_PER_STEP = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pulse,
    input  logic i_enable,
    output logic o_step
);

    localparam int CNT_W = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIODS_PER_STEP - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_count_en;

    assign w_count_en = i_pulse & i_enable;

    // Combinational so the sequencer updates on the completing pulse's own edge.
    assign o_step = w_count_en && (r_count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (o_step) begin
            r_count <= '0;
        end else if (w_count_en) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/hue_sequencer.sv
// Six-sector hue sweep: one channel ramps per sector, driving per-channel PWM
// duties. Optional freeze input `hold` is built only with HUE_SEQ_HOLD_EN.
module hue_sequencer
    import hue_seq_pkg::*;
#(
    parameter int  PWM_INTERVAL     = 1200,
    parameter int  STEP_SIZE        = 10,
    parameter int  PERIODS_PER_STEP = 1,
    localparam int DUTY_W           = duty_width(PWM_INTERVAL)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              period_end,
`ifdef HUE_SEQ_HOLD_EN
    input  logic              hold,
`endif
    output logic [DUTY_W-1:0] duty_r,
    output logic [DUTY_W-1:0] duty_g,
    output logic [DUTY_W-1:0] duty_b,
    output logic [2:0]        sector,
    output logic              wrap
);

    localparam logic [DUTY_W-1:0] FULL  = DUTY_W'(PWM_INTERVAL);
    localparam logic [DUTY_W-1:0] ZERO  = '0;
    localparam logic [DUTY_W:0]   STEP  = (DUTY_W + 1)'(STEP_SIZE);
    localparam logic [DUTY_W:0]   LIMIT = (DUTY_W + 1)'(PWM_INTERVAL);

    sector_t           r_state;
    logic [DUTY_W-1:0] r_level;
    logic [DUTY_W-1:0] r_duty_r;
    logic [DUTY_W-1:0] r_duty_g;
    logic [DUTY_W-1:0] r_duty_b;
    logic              r_wrap;

    logic                w_hold;
    logic                w_step;
    logic [DUTY_W:0]     w_sum;
    logic                w_roll;
    sector_t             w_next_state;
    logic [DUTY_W-1:0]   w_next_level;
    logic [3*DUTY_W-1:0] w_next_duty;

`ifdef HUE_SEQ_HOLD_EN
    assign w_hold = hold;
`else
    assign w_hold = 1'b0;
`endif

    hue_step_timer #(
        .PERIODS_PER_STEP (PERIODS_PER_STEP)
    ) u_step_timer (
        .clk      (clk),
        .rst      (rst),
        .i_pulse  (period_end),
        .i_enable (~w_hold),
        .o_step   (w_step)
    );

    // One extra bit keeps level+STEP_SIZE from wrapping before the compare.
    assign w_sum  = {1'b0, r_level} + STEP;
    assign w_roll = (w_sum >= LIMIT);

    assign w_next_state = (w_step && w_roll) ? next_sector(r_state) : r_state;
    assign w_next_level = !w_step ? r_level
                        : (w_roll ? ZERO : w_sum[DUTY_W-1:0]);

    // Channel duties {r, g, b} for a sector: one rising, one falling, one pinned.
    function automatic logic [3*DUTY_W-1:0] sector_duties(
        input sector_t           s,
        input logic [DUTY_W-1:0] lvl
    );
        logic [DUTY_W-1:0] fall;
        fall = FULL - lvl;
        case (s)
            S_G_UP:  return {FULL, lvl,  ZERO};
            S_R_DN:  return {fall, FULL, ZERO};
            S_B_UP:  return {ZERO, FULL, lvl };
            S_G_DN:  return {ZERO, fall, FULL};
            S_R_UP:  return {lvl,  ZERO, FULL};
            S_B_DN:  return {FULL, ZERO, fall};
            default: return {FULL, ZERO, ZERO};
        endcase
    endfunction

    assign w_next_duty = sector_duties(w_next_state, w_next_level);

    // Duties are loaded from the next state on the same edge as the state
    // itself, so outputs stay registered yet change on the step-event edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_G_UP;
            r_level  <= '0;
            r_duty_r <= FULL;
            r_duty_g <= '0;
            r_duty_b <= '0;
            r_wrap   <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere here so every register samples the
            // pre-edge values; blocking would leak new state into later lines.
            r_wrap <= w_step && w_roll && (r_state == S_B_DN);
            if (w_step) begin
                r_state                       <= w_next_state;
                r_level                       <= w_next_level;
                {r_duty_r, r_duty_g, r_duty_b} <= w_next_duty;
            end
        end
    end

    assign duty_r = r_duty_r;
    assign duty_g = r_duty_g;
    assign duty_b = r_duty_b;
    assign sector = r_state;
    assign wrap   = r_wrap;

endmodule

// File: tb/tb_hue_sequencer.sv
// Directed bench for hue_sequencer: two instances (STEP_SIZE 4 and 5) checked
// against a bench-side hue model through an expected-value queue.
module tb_hue_sequencer;

    localparam int MAX = 12;
    localparam int PPS = 2;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic       pe0  = 1'b0;
    logic       pe1  = 1'b0;
    logic       hold = 1'b0;
    logic [3:0] r0, g0, b0, r1, g1, b1;
    logic [2:0] s0, s1;
    logic       w0, w1;

    always #5 clk = ~clk;

    hue_sequencer #(
        .PWM_INTERVAL     (MAX),
        .STEP_SIZE        (4),
        .PERIODS_PER_STEP (PPS)
    ) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .period_end (pe0),
`ifdef HUE_SEQ_HOLD_EN
        .hold       (hold),
`endif
        .duty_r     (r0),
        .duty_g     (g0),
        .duty_b     (b0),
        .sector     (s0),
        .wrap       (w0)
    );

    hue_sequencer #(
        .PWM_INTERVAL     (MAX),
        .STEP_SIZE        (5),
        .PERIODS_PER_STEP (PPS)
    ) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .period_end (pe1),
`ifdef HUE_SEQ_HOLD_EN
        .hold       (hold),
`endif
        .duty_r     (r1),
        .duty_g     (g1),
        .duty_b     (b1),
        .sector     (s1),
        .wrap       (w1)
    );

    int n_asserts = 0;
    int n_fail    = 0;

    typedef struct {
        int    dut;
        int    r;
        int    g;
        int    b;
        int    sec;
        int    wrap;
        string tag;
    } exp_t;

    exp_t sb[$];

    int m_sec[2]  = '{0, 0};
    int m_lvl[2]  = '{0, 0};
    int m_cnt[2]  = '{0, 0};
    int m_step[2] = '{4, 5};

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_sec[d] = 0;
            m_lvl[d] = 0;
            m_cnt[d] = 0;
        end
    endtask

    task automatic model_pulse(input int d, output int wr);
        wr = 0;
        if (hold) return;
        m_cnt[d]++;
        if (m_cnt[d] == PPS) begin
            m_cnt[d] = 0;
            if (m_lvl[d] + m_step[d] >= MAX) begin
                m_lvl[d] = 0;
                m_sec[d] = (m_sec[d] + 1) % 6;
                if (m_sec[d] == 0) wr = 1;
            end else begin
                m_lvl[d] = m_lvl[d] + m_step[d];
            end
        end
    endtask

    task automatic push_exp(input int d, input int wr, input string tag);
        exp_t e;
        int   l;
        l = m_lvl[d];
        e.dut  = d;
        e.sec  = m_sec[d];
        e.wrap = wr;
        e.tag  = tag;
        case (m_sec[d])
            0:       begin e.r = MAX;     e.g = l;       e.b = 0;       end
            1:       begin e.r = MAX - l; e.g = MAX;     e.b = 0;       end
            2:       begin e.r = 0;       e.g = MAX;     e.b = l;       end
            3:       begin e.r = 0;       e.g = MAX - l; e.b = MAX;     end
            4:       begin e.r = l;       e.g = 0;       e.b = MAX;     end
            default: begin e.r = MAX;     e.g = 0;       e.b = MAX - l; end
        endcase
        sb.push_back(e);
    endtask

    task automatic compare_pop();
        exp_t e;
        e = sb.pop_front();
        if (e.dut == 0) begin
            check({e.tag, "_r"}, 32'(r0), e.r);
            check({e.tag, "_g"}, 32'(g0), e.g);
            check({e.tag, "_b"}, 32'(b0), e.b);
            check({e.tag, "_sector"}, 32'(s0), e.sec);
            check({e.tag, "_wrap"}, 32'(w0), e.wrap);
        end else begin
            check({e.tag, "_r"}, 32'(r1), e.r);
            check({e.tag, "_g"}, 32'(g1), e.g);
            check({e.tag, "_b"}, 32'(b1), e.b);
            check({e.tag, "_sector"}, 32'(s1), e.sec);
            check({e.tag, "_wrap"}, 32'(w1), e.wrap);
        end
    endtask

    task automatic expect_rgb(input int d, input string tag,
                              input int r, input int g, input int b, input int sec);
        if (d == 0) begin
            check({tag, "_r"}, 32'(r0), r);
            check({tag, "_g"}, 32'(g0), g);
            check({tag, "_b"}, 32'(b0), b);
            check({tag, "_sector"}, 32'(s0), sec);
        end else begin
            check({tag, "_r"}, 32'(r1), r);
            check({tag, "_g"}, 32'(g1), g);
            check({tag, "_b"}, 32'(b1), b);
            check({tag, "_sector"}, 32'(s1), sec);
        end
    endtask

    // Drives n high cycles of period_end on one instance; back_to_back keeps it
    // high continuously, otherwise each pulse is a single-cycle strobe.
    task automatic pulses(input int d, input int n, input bit back_to_back);
        int wr;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (d == 0) pe0 = 1'b1; else pe1 = 1'b1;
            model_pulse(d, wr);
            push_exp(d, wr, (d == 0) ? "pulse0" : "pulse1");
            @(posedge clk);
            #1;
            compare_pop();
            if (!back_to_back) begin
                @(negedge clk);
                pe0 = 1'b0;
                pe1 = 1'b0;
            end
        end
        if (back_to_back) begin
            @(negedge clk);
            pe0 = 1'b0;
            pe1 = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            push_exp(0, 0, "idle0");
            compare_pop();
            push_exp(1, 0, "idle1");
            compare_pop();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Asynchronous reset before any clock edge.
        #1 rst = 1'b1;
        #2;
        expect_rgb(0, "por0", MAX, 0, 0, 0);
        check("por0_wrap", 32'(w0), 0);
        expect_rgb(1, "por1", MAX, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        idle(5);

        pulses(0, 2, 1'b0);
        expect_rgb(0, "two_pulses", MAX, 4, 0, 0);
        pulses(0, 2, 1'b0);
        expect_rgb(0, "four_pulses", MAX, 8, 0, 0);
        pulses(0, 2, 1'b0);
        expect_rgb(0, "six_pulses", MAX, MAX, 0, 1);

        pulses(0, 29, 1'b0);
        check("pre_wrap", 32'(w0), 0);
        pulses(0, 1, 1'b0);
        check("wrap_36th", 32'(w0), 1);
        expect_rgb(0, "full_cycle", MAX, 0, 0, 0);
        idle(1);
        check("wrap_one_cycle", 32'(w0), 0);

        // Held-high period_end: four high cycles count as four pulses.
        pulses(0, 4, 1'b1);
        expect_rgb(0, "held_high", MAX, 8, 0, 0);

        pulses(1, 2, 1'b0);
        expect_rgb(1, "step5_a", MAX, 5, 0, 0);
        pulses(1, 2, 1'b0);
        expect_rgb(1, "step5_b", MAX, 10, 0, 0);
        pulses(1, 2, 1'b0);
        expect_rgb(1, "step5_roll", MAX, MAX, 0, 1);
        pulses(1, 12, 1'b0);

        // Walk instance 0 into sector 2 with a partial count, then reset mid-cycle.
        pulses(0, 2, 1'b0);
        pulses(0, 6, 1'b0);
        pulses(0, 2, 1'b0);
        expect_rgb(0, "sector2", 0, MAX, 4, 2);
        pulses(0, 1, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        expect_rgb(0, "rst_mid", MAX, 0, 0, 0);
        check("rst_mid_wrap", 32'(w0), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        pulses(0, 1, 1'b0);
        expect_rgb(0, "rst_partial", MAX, 0, 0, 0);
        pulses(0, 1, 1'b0);
        expect_rgb(0, "rst_first_step", MAX, 4, 0, 0);

`ifdef HUE_SEQ_HOLD_EN
        hold = 1'b1;
        pulses(0, 10, 1'b0);
        expect_rgb(0, "hold_frozen", MAX, 4, 0, 0);
        hold = 1'b0;
        pulses(0, 2, 1'b0);
        expect_rgb(0, "hold_release", MAX, 8, 0, 0);
`endif

        check("sb_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
